// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: default sizing and the
// broadcast packet that the map table and reservation stations consume.
package cdb_arbiter_pkg;

    localparam int DEF_NUM_FU  = 4;
    localparam int DEF_TAG_LEN = 5;
    localparam int DEF_XLEN    = 32;

    // One CDB broadcast as seen by the consumers; the integrating level packs
    // the arbiter's cdb_* outputs into this.
    typedef struct packed {
        logic                   valid;
        logic [DEF_TAG_LEN-1:0] tag;
        logic [DEF_XLEN-1:0]    value;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
//
// Handshake: an FU raises fu_req_valid[i] with its tag/value and holds all
// three stable until it sees fu_req_ready[i] high; the request is consumed on
// the rising clock edge where valid and ready are both high. fu_req_ready is
// one-hot-or-zero and never depends on tag or value. The cdb_* outputs are a
// registered broadcast, present for exactly the one cycle after the grant.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU  = DEF_NUM_FU,
    parameter int TAG_LEN = DEF_TAG_LEN,
    parameter int XLEN    = DEF_XLEN
);
    localparam int IW = $clog2(NUM_FU);

    logic [NUM_FU-1:0]         fu_req_valid;
    logic [NUM_FU*TAG_LEN-1:0] fu_req_tag;
    logic [NUM_FU*XLEN-1:0]    fu_req_value;
    logic [NUM_FU-1:0]         fu_req_ready;

    logic                      cdb_valid;
    logic [TAG_LEN-1:0]        cdb_tag;
    logic [XLEN-1:0]           cdb_value;
    logic [IW-1:0]             cdb_grant_idx;

    // Functional-unit side: presents requests, observes grants and the bus.
    modport master (
        output fu_req_valid, fu_req_tag, fu_req_value,
        input  fu_req_ready,
        input  cdb_valid, cdb_tag, cdb_value, cdb_grant_idx
    );

    // Arbiter side.
    modport slave (
        input  fu_req_valid, fu_req_tag, fu_req_value,
        output fu_req_ready,
        output cdb_valid, cdb_tag, cdb_value, cdb_grant_idx
    );

endinterface

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Rotating first-one search: picks the first set request bit starting at
// rr_ptr and wrapping modulo NUM_FU. Purely combinational.
module rr_priority_picker #(
    parameter  int NUM_FU = 4,
    localparam int IW     = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [IW-1:0]     rr_ptr,
    output logic [NUM_FU-1:0] grant,
    output logic [IW-1:0]     grant_idx,
    output logic              any_grant
);

    logic [IW-1:0] probe;

    // Walk offsets 0..NUM_FU-1 from rr_ptr; NUM_FU is a power of two, so the
    // IW-bit add wraps exactly at NUM_FU. The first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        probe     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            probe = rr_ptr + IW'(k);
            if (!any_grant && req[probe]) begin
                any_grant    = 1'b1;
                grant_idx    = probe;
                grant[probe] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units with a
// one-cycle registered broadcast of the winner's tag and value.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU  = DEF_NUM_FU,
    parameter int TAG_LEN = DEF_TAG_LEN,
    parameter int XLEN    = DEF_XLEN
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    cdb_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NUM_FU);

    logic [IW-1:0]      rr_ptr;
    logic [NUM_FU-1:0]  req_eligible;
    logic [NUM_FU-1:0]  grant;
    logic [IW-1:0]      grant_idx;
    logic               any_grant;
    logic [TAG_LEN-1:0] sel_tag;
    logic [XLEN-1:0]    sel_value;

    logic               cdb_valid_q;
    logic [TAG_LEN-1:0] cdb_tag_q;
    logic [XLEN-1:0]    cdb_value_q;
    logic [IW-1:0]      cdb_grant_idx_q;

    // Squash and reset both suppress arbitration; only valid bits feed the
    // picker, so the grant never depends on tag or value.
    assign req_eligible = (reset || squash) ? '0 : bus.fu_req_valid;

    rr_priority_picker #(.NUM_FU(NUM_FU)) u_picker (
        .req       (req_eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign bus.fu_req_ready = grant;
    assign sel_tag          = bus.fu_req_tag[int'(grant_idx)*TAG_LEN +: TAG_LEN];
    assign sel_value        = bus.fu_req_value[int'(grant_idx)*XLEN +: XLEN];

    // Consume the granted request: advance the pointer past the winner and
    // register its broadcast; idle or squashed cycles load an all-zero bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr          <= '0;
            cdb_valid_q     <= 1'b0;
            cdb_tag_q       <= '0;
            cdb_value_q     <= '0;
            cdb_grant_idx_q <= '0;
        end else if (any_grant) begin
            rr_ptr          <= grant_idx + IW'(1);
            cdb_valid_q     <= 1'b1;
            cdb_tag_q       <= sel_tag;
            cdb_value_q     <= sel_value;
            cdb_grant_idx_q <= grant_idx;
        end else begin
            cdb_valid_q     <= 1'b0;
            cdb_tag_q       <= '0;
            cdb_value_q     <= '0;
            cdb_grant_idx_q <= '0;
        end
    end

    assign bus.cdb_valid     = cdb_valid_q;
    assign bus.cdb_tag       = cdb_tag_q;
    assign bus.cdb_value     = cdb_value_q;
    assign bus.cdb_grant_idx = cdb_grant_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_FU=4, TAG_LEN=5, XLEN=32). The driver
// pushes the expected broadcast for every grant it expects; a monitor pops and
// compares whenever the bus shows a valid broadcast.
module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int TL = 5;
    localparam int XL = 32;
    localparam int W  = 2 + TL + XL;

    logic clock;
    logic reset;
    logic squash;

    int checks;
    int errors;

    logic [W-1:0]  exp_q[$];
    logic [TL-1:0] fu_tag[NF];
    logic [XL-1:0] fu_val[NF];

    cdb_arbiter_if #(.NUM_FU(NF), .TAG_LEN(TL), .XLEN(XL)) bus ();

    cdb_arbiter #(.NUM_FU(NF), .TAG_LEN(TL), .XLEN(XL)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus.slave)
    );

    // Clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " cdb_valid"}, 64'(bus.cdb_valid), 64'd0);
        check({name, " cdb_tag"}, 64'(bus.cdb_tag), 64'd0);
        check({name, " cdb_value"}, 64'(bus.cdb_value), 64'd0);
        check({name, " cdb_grant_idx"}, 64'(bus.cdb_grant_idx), 64'd0);
        check({name, " fu_req_ready"}, 64'(bus.fu_req_ready), 64'd0);
    endtask

    // Driver: present one cycle of requests, record the expected broadcast,
    // then check the combinational grant mid-cycle.
    task automatic apply(input logic [NF-1:0] v, input logic sq,
                         input logic [NF-1:0] exp_rdy, input string name);
        @(posedge clock);
        #1;
        bus.fu_req_valid = v;
        squash = sq;
        for (int i = 0; i < NF; i++) begin
            bus.fu_req_tag[i*TL +: TL]   = fu_tag[i];
            bus.fu_req_value[i*XL +: XL] = fu_val[i];
        end
        for (int i = 0; i < NF; i++) begin
            if (exp_rdy[i]) exp_q.push_back({2'(i), fu_tag[i], fu_val[i]});
        end
        @(negedge clock);
        check({name, " ready"}, 64'(bus.fu_req_ready), 64'(exp_rdy));
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        logic [W-1:0] exp;
        if (bus.cdb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected: got idx=%0d tag=%0d value=%h, expected no broadcast",
                         bus.cdb_grant_idx, bus.cdb_tag, bus.cdb_value);
            end else begin
                exp = exp_q.pop_front();
                if ({bus.cdb_grant_idx, bus.cdb_tag, bus.cdb_value} !== exp) begin
                    errors++;
                    $display("FAIL cdb_broadcast: got idx=%0d tag=%0d value=%h, expected idx=%0d tag=%0d value=%h",
                             bus.cdb_grant_idx, bus.cdb_tag, bus.cdb_value,
                             exp[W-1 -: 2], exp[XL +: TL], exp[XL-1:0]);
                end
            end
        end else begin
            checks++;
            if ({bus.cdb_valid, bus.cdb_grant_idx, bus.cdb_tag, bus.cdb_value} !== '0) begin
                errors++;
                $display("FAIL cdb_idle_zero: got valid=%b idx=%0d tag=%0d value=%h, expected all zero",
                         bus.cdb_valid, bus.cdb_grant_idx, bus.cdb_tag, bus.cdb_value);
            end
        end
    end

    // Directed sequence
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        squash = 1'b0;
        bus.fu_req_valid = '0;
        bus.fu_req_tag   = '0;
        bus.fu_req_value = '0;
        for (int i = 0; i < NF; i++) begin
            fu_tag[i] = TL'(3 * i + 1);
            fu_val[i] = 32'hC0DE_0000 + 32'(i * 32'h11);
        end

        // Async reset before any clock edge
        #1 reset = 1'b1;
        #1 check_all_zero("reset_async_t0");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Move rr_ptr away from zero, then reset mid-broadcast
        apply(4'b0010, 1'b0, 4'b0010, "fu1_only");
        apply(4'b0000, 1'b0, 4'b0000, "idle_a");
        apply(4'b0100, 1'b0, 4'b0100, "fu2_pre_reset");
        @(posedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        bus.fu_req_valid = 4'b1111;
        #1 check_all_zero("reset_mid_broadcast");
        bus.fu_req_valid = 4'b0000;
        @(negedge clock);
        reset = 1'b0;

        // All four requesting: order 0,1,2,3,0,1,2,3 from reset pointer
        for (int c = 0; c < 8; c++) begin
            apply(4'b1111, 1'b0, 4'(1 << (c % 4)), "all_four");
        end

        // Single requester with a specific payload
        fu_tag[2] = 5'd7;
        fu_val[2] = 32'hDEAD_BEEF;
        apply(4'b0100, 1'b0, 4'b0100, "fu2_deadbeef");
        fu_tag[2] = TL'(7);
        fu_val[2] = 32'hC0DE_0022;
        apply(4'b0000, 1'b0, 4'b0000, "idle_b");

        // Wrap from rr_ptr=3 to FU0, then FU1
        apply(4'b0011, 1'b0, 4'b0001, "wrap_fu0");
        apply(4'b0011, 1'b0, 4'b0010, "wrap_fu1");

        // Squash: grant FU3 first so its broadcast shows during the squash
        apply(4'b1010, 1'b0, 4'b1000, "pre_squash_fu3");
        apply(4'b1010, 1'b1, 4'b0000, "squash_1");
        apply(4'b1010, 1'b1, 4'b0000, "squash_2");
        apply(4'b1010, 1'b0, 4'b0010, "post_squash_fu1");
        apply(4'b1010, 1'b0, 4'b1000, "post_squash_fu3");

        apply(4'b0000, 1'b0, 4'b0000, "drain_1");
        apply(4'b0000, 1'b0, 4'b0000, "drain_2");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
